nes_joypad_shifter: RTL

- Consumer-side counterpart of the USB HID report decoder.
- Takes the decoded 8-bit NES button state and presents it to the NES core as a standard 4021-style controller on the $4016/$4017 interface: parallel latch while strobe is high, serial shift on each CPU read.
- Adds a report-staleness watchdog. If the USB side stops delivering reports, all buttons are released so none stay stuck.

---
 rtl/nes_joypad_pkg.sv | 26 ++
 rtl/nes_joypad_watchdog.sv | 42 ++++
 rtl/nes_joypad_shifter.sv | 48 ++++
 3 files changed

// File: rtl/nes_joypad_pkg.sv
// nes_joypad_pkg: button bit positions, shift fill value and the SOCD clean-up helper.
package nes_joypad_pkg;
    typedef logic [7:0] btn_t;
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    // An official 4021 pad shifts in ones, so reads 9+ return 1
    localparam logic SHIFT_FILL = 1'b1;
    // Opposing D-pad directions cancel out instead of reaching the game
    function automatic btn_t socd_clean(input btn_t b);
        socd_clean = b;
        if (b[BTN_UP] && b[BTN_DOWN]) begin
            socd_clean[BTN_UP]   = 1'b0;
            socd_clean[BTN_DOWN] = 1'b0;
        end
        if (b[BTN_LEFT] && b[BTN_RIGHT]) begin
            socd_clean[BTN_LEFT]  = 1'b0;
            socd_clean[BTN_RIGHT] = 1'b0;
        end
    endfunction
endpackage

// File: rtl/nes_joypad_watchdog.sv
// nes_joypad_watchdog: report-staleness timer.
// Ports: i_clk, i_rst_n (async active-low), i_btn_valid (report strobe),
//        o_expire (one-cycle pulse on the cycle the timeout is reached, valid wins),
//        o_stale (high from reset / expiry until the next report).
module nes_joypad_watchdog
    import nes_joypad_pkg::*;
#(
    parameter int C_CLK_HZ     = 48000000,
    parameter int C_TIMEOUT_MS = 100
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn_valid,
    output logic o_expire,
    output logic o_stale
);
    localparam int C_LIMIT = C_CLK_HZ / 1000 * C_TIMEOUT_MS;
    generate
        if (C_LIMIT > 0) begin : g_wd
            localparam int W = $clog2(C_LIMIT) + 1;
            logic [W-1:0] cnt;
            // Fires on the edge that takes the counter to the limit
            assign o_expire = !i_btn_valid && cnt == W'(C_LIMIT - 1);
            always_ff @(posedge i_clk or negedge i_rst_n)
                if (!i_rst_n) begin
                    cnt     <= '0;
                    o_stale <= 1'b1;
                end else if (i_btn_valid) begin
                    cnt     <= '0;
                    o_stale <= 1'b0;
                end else begin
                    if (cnt != W'(C_LIMIT)) cnt <= cnt + W'(1);
                    if (o_expire) o_stale <= 1'b1;
                end
        end else begin : g_nowd
            assign o_expire = 1'b0;
            always_ff @(posedge i_clk or negedge i_rst_n)
                if (!i_rst_n) o_stale <= 1'b1;
                else if (i_btn_valid) o_stale <= 1'b0;
        end
    endgenerate
endmodule

// File: rtl/nes_joypad_shifter.sv
// nes_joypad_shifter: 4021-style NES controller fed from decoded USB button reports.
// Ports: i_clk, i_rst_n (async active-low), i_btn[7:0] {right,left,down,up,start,select,b,a},
//        i_btn_valid, i_strobe (latch level), i_read (one pulse per CPU read),
//        o_data (serial button bit), o_stale (no recent report).
// Macro NES_JOYPAD_SOCD_CLEAN_EN: cancel opposing D-pad directions before holding.
module nes_joypad_shifter
    import nes_joypad_pkg::*;
#(
    parameter int C_CLK_HZ     = 48000000,
    parameter int C_TIMEOUT_MS = 100
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_btn,
    input  logic       i_btn_valid,
    input  logic       i_strobe,
    input  logic       i_read,
    output logic       o_data,
    output logic       o_stale
);
    btn_t btn_f, r_hold, r_shift;
    logic wd_expire;
`ifdef NES_JOYPAD_SOCD_CLEAN_EN
    assign btn_f = socd_clean(i_btn);
`else
    assign btn_f = i_btn;
`endif
    nes_joypad_watchdog #(
        .C_CLK_HZ    (C_CLK_HZ),
        .C_TIMEOUT_MS(C_TIMEOUT_MS)
    ) u_wd (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_btn_valid(i_btn_valid),
        .o_expire   (wd_expire),
        .o_stale    (o_stale)
    );
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) r_hold <= '0;
        else if (i_btn_valid) r_hold <= btn_f;
        else if (wd_expire) r_hold <= '0;
    // Strobe high keeps reloading and masks reads; a rising strobe discards unread bits
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) r_shift <= '0;
        else if (i_strobe) r_shift <= r_hold;
        else if (i_read) r_shift <= {SHIFT_FILL, r_shift[7:1]};
    assign o_data = r_shift[BTN_A];
endmodule
